// File: rtl/clint_mh.sv
// Multi-hart core-local interruptor: shared prescaled 64-bit mtime, per-hart
// mtimecmp/msip, registered timer IRQs, zero-wait-state APB slave.
module clint_mh #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NUM_HARTS      = 4,
    parameter int TICK_DIV       = 1
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic [NUM_HARTS-1:0]      msi_o,
    output logic [NUM_HARTS-1:0]      mti_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

    logic [11:0]          off;
    logic                 upper_ok;
    logic [4:0]           msip_idx;
    logic [4:0]           cmp_idx;
    logic                 sel_msip, sel_cmp, sel_ctrl, sel_mlo, sel_mhi;
    logic                 hit, access, wr_en, mtime_wr, tick;

    logic [63:0]          mtime;
    logic [63:0]          mtimecmp [NUM_HARTS];
    logic [NUM_HARTS-1:0] msip;
    logic [NUM_HARTS-1:0] mti_q;
    logic                 timer_en;
    logic [PW-1:0]        presc;
    logic [31:0]          rdata;

    // Address bits above the 4 KiB window must be zero for a hit.
    generate
        if (APB_ADDR_WIDTH > 12) begin : g_upper
            assign upper_ok = ~|PADDR[APB_ADDR_WIDTH-1:12];
        end else begin : g_no_upper
            assign upper_ok = 1'b1;
        end
    endgenerate

    assign off      = PADDR[11:0];
    assign msip_idx = off[6:2];
    assign cmp_idx  = off[7:3];

    assign sel_msip = upper_ok && (off[11:7] == 5'd0) && (int'(msip_idx) < NUM_HARTS);
    assign sel_cmp  = upper_ok && (off[11:8] == 4'h1) && (int'(cmp_idx) < NUM_HARTS);
    assign sel_ctrl = upper_ok && (off[11:2] == 10'h1FC);
    assign sel_mlo  = upper_ok && (off[11:2] == 10'h1FE);
    assign sel_mhi  = upper_ok && (off[11:2] == 10'h1FF);

    assign hit      = sel_msip | sel_cmp | sel_ctrl | sel_mlo | sel_mhi;
    assign access   = PSEL & PENABLE;
    assign wr_en    = access & PWRITE & hit;
    assign mtime_wr = wr_en & (sel_mlo | sel_mhi);
    assign tick     = timer_en && (presc == PS_LAST);

    // A software write to either mtime half wins over a coincident tick.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            mtime    <= '0;
            presc    <= '0;
            timer_en <= 1'b1;
        end else begin
            if (mtime_wr) begin
                presc <= '0;
                if (sel_mlo) mtime[31:0]  <= PWDATA;
                else         mtime[63:32] <= PWDATA;
            end else if (timer_en) begin
                if (tick) begin
                    presc <= '0;
                    mtime <= mtime + 64'd1;
                end else begin
                    presc <= presc + 1'b1;
                end
            end
            if (wr_en && sel_ctrl) timer_en <= PWDATA[0];
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            msip  <= '0;
            mti_q <= '0;
            for (int h = 0; h < NUM_HARTS; h++) mtimecmp[h] <= '1;
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (wr_en && sel_msip && (int'(msip_idx) == h)) msip[h] <= PWDATA[0];
                if (wr_en && sel_cmp && (int'(cmp_idx) == h)) begin
                    if (off[2]) mtimecmp[h][63:32] <= PWDATA;
                    else        mtimecmp[h][31:0]  <= PWDATA;
                end
                mti_q[h] <= (mtime >= mtimecmp[h]);
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (access) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (sel_msip && (int'(msip_idx) == h)) rdata = {31'd0, msip[h]};
                if (sel_cmp && (int'(cmp_idx) == h))
                    rdata = off[2] ? mtimecmp[h][63:32] : mtimecmp[h][31:0];
            end
            if (sel_ctrl) rdata = {31'd0, timer_en};
            if (sel_mlo)  rdata = mtime[31:0];
            if (sel_mhi)  rdata = mtime[63:32];
        end
    end

    assign PRDATA  = rdata;
    assign PSLVERR = access & ~hit;
    assign PREADY  = 1'b1;
    assign msi_o   = msip;
    assign mti_o   = mti_q;

endmodule

// File: tb/tb_clint_mh.sv
// Bench for clint_mh: two instances (TICK_DIV=4 and TICK_DIV=1) on one APB bus,
// checked every cycle against a register-map model plus literal scenario checks.
module tb_clint_mh;

    localparam int NH = 4;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE, PSEL, PENABLE;

    logic [31:0]   prdata_a, prdata_b;
    logic          pready_a, pready_b, pslverr_a, pslverr_b;
    logic [NH-1:0] msi_a, msi_b, mti_a, mti_b;

    always #5 PCLK = ~PCLK;

    clint_mh #(.APB_ADDR_WIDTH(12), .NUM_HARTS(NH), .TICK_DIV(4)) u_d4 (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(prdata_a), .PREADY(pready_a),
        .PSLVERR(pslverr_a), .msi_o(msi_a), .mti_o(mti_a));

    clint_mh #(.APB_ADDR_WIDTH(12), .NUM_HARTS(NH), .TICK_DIV(1)) u_d1 (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(prdata_b), .PREADY(pready_b),
        .PSLVERR(pslverr_b), .msi_o(msi_b), .mti_o(mti_b));

    // Model state, index 0 = TICK_DIV 4 instance, 1 = TICK_DIV 1 instance
    logic [63:0]   m_mt  [2];
    logic [63:0]   m_cmp [2][NH];
    logic [NH-1:0] m_msip[2];
    logic [NH-1:0] m_mti [2];
    logic          m_en  [2];
    int            m_pc  [2];

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] rd_a, rd_b;
    logic        err_a;

    function automatic int divk(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mt[k] = 64'd0; m_msip[k] = '0; m_mti[k] = '0; m_en[k] = 1'b1; m_pc[k] = 0;
            for (int h = 0; h < NH; h++) m_cmp[k][h] = '1;
        end
    endtask

    // {pslverr, prdata} the register map says an access to a must return
    function automatic logic [32:0] exp_read(input int k, input logic [11:0] a);
        int w;
        int h;
        w = int'(a) & 32'hFFC;
        if (w < 4 * NH) return {1'b0, 31'd0, m_msip[k][w / 4]};
        if (w >= 'h100 && w < 'h100 + 8 * NH) begin
            h = (w - 'h100) / 8;
            if (w % 8 == 4) return {1'b0, m_cmp[k][h][63:32]};
            return {1'b0, m_cmp[k][h][31:0]};
        end
        if (w == 'h7F0) return {1'b0, 31'd0, m_en[k]};
        if (w == 'h7F8) return {1'b0, m_mt[k][31:0]};
        if (w == 'h7FC) return {1'b0, m_mt[k][63:32]};
        return {1'b1, 32'd0};
    endfunction

    task automatic model_step(input logic s, input logic e, input logic w,
                              input logic [11:0] a, input logic [31:0] d);
        for (int k = 0; k < 2; k++) begin
            logic [NH-1:0] nm;
            int  wa;
            logic acc_w;
            for (int h = 0; h < NH; h++) nm[h] = (m_mt[k] >= m_cmp[k][h]);
            wa    = int'(a) & 32'hFFC;
            acc_w = s && e && w;
            if (acc_w && (wa == 'h7F8 || wa == 'h7FC)) begin
                if (wa == 'h7F8) m_mt[k][31:0] = d;
                else             m_mt[k][63:32] = d;
                m_pc[k] = 0;
            end else if (m_en[k]) begin
                if (m_pc[k] == divk(k) - 1) begin
                    m_mt[k] = m_mt[k] + 64'd1;
                    m_pc[k] = 0;
                end else begin
                    m_pc[k] = m_pc[k] + 1;
                end
            end
            if (acc_w) begin
                if (wa < 4 * NH) m_msip[k][wa / 4] = d[0];
                else if (wa >= 'h100 && wa < 'h100 + 8 * NH) begin
                    if (wa % 8 == 4) m_cmp[k][(wa - 'h100) / 8][63:32] = d;
                    else             m_cmp[k][(wa - 'h100) / 8][31:0]  = d;
                end else if (wa == 'h7F0) m_en[k] = d[0];
            end
            m_mti[k] = nm;
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input logic acc, input logic [11:0] a);
        for (int k = 0; k < 2; k++) begin
            logic [32:0] ex;
            ex = acc ? exp_read(k, a) : 33'd0;
            chk($sformatf("d%0d prdata @%0h", k, a), (k == 0) ? prdata_a : prdata_b, ex[31:0]);
            chk($sformatf("d%0d pslverr @%0h", k, a), (k == 0) ? pslverr_a : pslverr_b, ex[32]);
            chk($sformatf("d%0d msi_o", k), (k == 0) ? msi_a : msi_b, m_msip[k]);
            chk($sformatf("d%0d mti_o", k), (k == 0) ? mti_a : mti_b, m_mti[k]);
            chk($sformatf("d%0d pready", k), (k == 0) ? pready_a : pready_b, 1'b1);
        end
    endtask

    // One bus cycle: drive after negedge, check, clock, advance model.
    task automatic step(input logic s, input logic e, input logic w,
                        input logic [11:0] a, input logic [31:0] d);
        PSEL = s; PENABLE = e; PWRITE = w; PADDR = a; PWDATA = d;
        #1;
        rd_a  = prdata_a;
        rd_b  = prdata_b;
        err_a = pslverr_a;
        check_outputs(s & e, a);
        @(posedge PCLK);
        model_step(s, e, w, a, d);
        @(negedge PCLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 12'h000, 32'd0);
    endtask

    task automatic apb_wr(input logic [11:0] a, input logic [31:0] d);
        step(1'b1, 1'b0, 1'b1, a, d);
        step(1'b1, 1'b1, 1'b1, a, d);
    endtask

    task automatic apb_rd(input logic [11:0] a);
        step(1'b1, 1'b0, 1'b0, a, 32'd0);
        step(1'b1, 1'b1, 1'b0, a, 32'd0);
    endtask

    function automatic logic [11:0] rand_addr();
        case ($urandom_range(0, 8))
            0:       return 12'(4 * $urandom_range(0, NH - 1));
            1:       return 12'(4 * $urandom_range(NH, 31));
            2, 3:    return 12'('h100 + 4 * $urandom_range(0, 2 * NH - 1));
            4:       return 12'('h100 + 8 * NH + 4 * $urandom_range(0, 63 - 2 * NH));
            5:       return 12'h7F0;
            6:       return ($urandom_range(0, 1) == 1) ? 12'h7F8 : 12'h7FC;
            7:       return 12'h7F4;
            default: return 12'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
        PRESET = 1'b1;
        model_reset();
        repeat (2) @(negedge PCLK);
        #1;
        chk("reset mti_o", mti_a, 4'b0000);
        chk("reset msi_o", msi_a, 4'b0000);
        @(negedge PCLK);
        PRESET = 1'b0;

        apb_rd(12'h7F8); chk("reset mtime lo", rd_a, 32'h0); chk("reset pslverr", err_a, 1'b0);
        apb_rd(12'h7FC); chk("reset mtime hi", rd_a, 32'h0);
        apb_rd(12'h100); chk("reset mtimecmp0 lo", rd_a, 32'hFFFF_FFFF);

        // Prescaler by 4: 40 cycles give 10 ticks; disable coincides with a tick
        apb_wr(12'h7FC, 32'd0);
        apb_wr(12'h7F8, 32'd0);
        idle(40);
        apb_rd(12'h7F8); chk("div4 mtime after 40", rd_a, 32'd10);
        apb_wr(12'h7F0, 32'd0);
        apb_rd(12'h7F8); chk("mtime at disable", rd_a, 32'd11);
        idle(20);
        apb_rd(12'h7F8); chk("mtime frozen", rd_a, 32'd11);

        apb_wr(12'h7F0, 32'd1);
        apb_wr(12'h7F8, 32'hFFFF_FFFF);
        apb_wr(12'h7FC, 32'd0);
        idle(6);
        apb_rd(12'h7F8); chk("carry lo", rd_a, 32'd0);
        apb_rd(12'h7FC); chk("carry hi", rd_a, 32'd1);

        // Timer compare on the TICK_DIV=1 instance
        apb_wr(12'h7FC, 32'd0);
        apb_wr(12'h7F8, 32'd0);
        apb_wr(12'h114, 32'd0);
        apb_wr(12'h110, 32'd100);
        n = 0;
        while (mti_b[2] !== 1'b1 && n < 300) begin
            idle(1);
            n++;
        end
        chk("mti rise within bound", (n < 300), 1'b1);
        chk("d1 mti after rise", mti_b, 4'b0100);
        chk("model mtime at rise", m_mt[1], 64'd101);
        apb_wr(12'h110, 32'd200);
        idle(1);
        chk("d1 mti after cmp raise", mti_b, 4'b0000);

        apb_wr(12'h008, 32'd1);
        chk("msip2 set", msi_a, 4'b0100);
        apb_wr(12'h008, 32'hFFFF_FFFE);
        chk("msip2 clear", msi_b, 4'b0000);
        apb_rd(12'h008); chk("msip2 readback", rd_a, 32'd0);

        apb_rd(12'h010); chk("hart4 msip err", err_a, 1'b1); chk("hart4 msip data", rd_a, 32'd0);
        apb_rd(12'h200); chk("0x200 err", err_a, 1'b1); chk("0x200 data", rd_a, 32'd0);
        apb_wr(12'h010, 32'd1);
        chk("bad msip write ignored", msi_a, 4'b0000);
        apb_wr(12'h200, 32'd0);
        apb_rd(12'h100); chk("bad write cmp0 intact", rd_a, 32'hFFFF_FFFF);

        // Asynchronous reset mid-operation
        apb_wr(12'h004, 32'd1);
        apb_wr(12'h104, 32'd0);
        apb_wr(12'h100, 32'd0);
        idle(1);
        chk("pre-reset msi", msi_a, 4'b0010);
        chk("pre-reset mti", mti_b, 4'b0001);
        PRESET = 1'b1;
        model_reset();
        #1;
        chk("async reset msi", msi_a, 4'b0000);
        chk("async reset mti d4", mti_a, 4'b0000);
        chk("async reset mti d1", mti_b, 4'b0000);
        check_outputs(1'b0, 12'h000);
        @(negedge PCLK);
        PRESET = 1'b0;
        apb_rd(12'h7F8); chk("post-reset mtime", rd_a, 32'd0);

        for (int i = 0; i < 300; i++) begin
            logic [11:0] a;
            logic [31:0] d;
            a = rand_addr();
            d = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 400);
            if (a[11:2] == 10'h1FC && $urandom_range(0, 3) != 0) d = 32'd1;
            idle($urandom_range(0, 2));
            if ($urandom_range(0, 2) == 0) apb_rd(a);
            else                           apb_wr(a, d);
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
